incubator_scan_ctrl: RTL and testbench

- Multi-chamber supervisor for the incubator climate system.
- Polls one shared temperature sensor port across N_CH chambers, using a mux select and a req/ack handshake.
- Applies hysteresis heat/cool decisions with minimum-hold protection per chamber.
- Drives per-chamber heater and cooler enables. Sits between the shared sensor front-end and the chamber actuators.

---
 rtl/incubator_pkg.sv | 48 ++++
 rtl/incubator_chan_mode.sv | 70 +++++++
 rtl/incubator_scan_ctrl.sv | 113 +++++++++++
 tb/tb_incubator_scan_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/incubator_pkg.sv
// Shared types and default thresholds for the incubator climate supervisor.
// Imported by the scan controller and the per-chamber mode tracker.
package incubator_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_HEAT = 2'd1,
        MODE_COOL = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EVAL = 3'd3,
        ST_NEXT = 3'd4
    } scan_state_e;

    localparam logic signed [7:0] LO_TH = 8'sd15;
    localparam logic signed [7:0] HI_TH = 8'sd35;
    localparam logic signed [7:0] SETPT = 8'sd25;

    // Hysteresis target for one reading; HEAT and COOL can only return to OFF.
    function automatic mode_e next_mode(input mode_e cur, input logic signed [7:0] rd,
                                        input logic signed [7:0] lo, input logic signed [7:0] hi,
                                        input logic signed [7:0] sp);
        mode_e nxt;
        nxt = cur;
        case (cur)
            MODE_OFF: begin
                if (rd < lo) nxt = MODE_HEAT;
                else if (rd > hi) nxt = MODE_COOL;
                else nxt = MODE_OFF;
            end
            MODE_HEAT: begin
                if (rd >= sp) nxt = MODE_OFF;
                else nxt = MODE_HEAT;
            end
            MODE_COOL: begin
                if (rd <= sp) nxt = MODE_OFF;
                else nxt = MODE_COOL;
            end
            default: nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/incubator_chan_mode.sv
// Per-chamber mode tracker: hysteresis mode, minimum-hold counter and sticky
// sensor-timeout fault, with registered heater/cooler enables.
module incubator_chan_mode #(
    parameter logic signed [7:0] LO_TH    = incubator_pkg::LO_TH,
    parameter logic signed [7:0] HI_TH    = incubator_pkg::HI_TH,
    parameter logic signed [7:0] SETPT    = incubator_pkg::SETPT,
    parameter int unsigned       MIN_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eval_i,
    input  logic              tmo_i,
    input  logic signed [7:0] reading_i,
    output logic              heater_o,
    output logic              cooler_o,
    output logic              fault_o
);
    import incubator_pkg::*;

    localparam int unsigned     HW       = $clog2(MIN_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MIN_HOLD);

    mode_e         mode_q, mode_d, want_s;
    logic [HW-1:0] hold_q, hold_d;
    logic          fault_q, fault_d;
    logic          heater_q, cooler_q;

    // A timeout forces OFF regardless of hold; an eval may change mode only once hold saturates.
    always_comb begin
        want_s  = next_mode(mode_q, reading_i, LO_TH, HI_TH, SETPT);
        mode_d  = mode_q;
        fault_d = fault_q;
        if (tmo_i) begin
            fault_d = 1'b1;
            mode_d  = MODE_OFF;
        end else if (eval_i && !fault_q && (want_s != mode_q) && (hold_q >= HOLD_MAX)) begin
            mode_d = want_s;
        end else begin
            mode_d = mode_q;
        end
        if (mode_d != mode_q) begin
            hold_d = '0;
        end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            hold_q   <= '0;
            fault_q  <= 1'b0;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            fault_q  <= fault_d;
            heater_q <= (mode_d == MODE_HEAT);
            cooler_q <= (mode_d == MODE_COOL);
        end
    end

    assign heater_o = heater_q;
    assign cooler_o = cooler_q;
    assign fault_o  = fault_q;

endmodule

// File: rtl/incubator_scan_ctrl.sv
// Multi-chamber supervisor: round-robin polls a shared temperature sensor with a
// req/ack handshake and feeds each reading to that chamber's mode tracker.
module incubator_scan_ctrl #(
    parameter int unsigned       N_CH     = 4,
    parameter logic signed [7:0] LO_TH    = incubator_pkg::LO_TH,
    parameter logic signed [7:0] HI_TH    = incubator_pkg::HI_TH,
    parameter logic signed [7:0] SETPT    = incubator_pkg::SETPT,
    parameter int unsigned       MIN_HOLD = 8,
    parameter int unsigned       ACK_TMO  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    output logic [$clog2(N_CH)-1:0] sns_sel_o,
    output logic                    sns_req_o,
    input  logic                    sns_ack_i,
    input  logic signed [7:0]       sns_data_i,
    output logic [N_CH-1:0]         heater_o,
    output logic [N_CH-1:0]         cooler_o,
    output logic [N_CH-1:0]         fault_o,
    output logic                    scan_done_o
);
    import incubator_pkg::*;

    localparam int unsigned   CW       = $clog2(N_CH);
    localparam int unsigned   TW       = $clog2(ACK_TMO + 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);
    localparam logic [TW-1:0] LAST_TMO = TW'(ACK_TMO - 1);

    scan_state_e       state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic signed [7:0] data_q, data_d;
    logic              eval_s, tmo_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            tmo_cnt_q <= '0;
            data_q    <= 8'sd0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            tmo_cnt_q <= tmo_cnt_d;
            data_q    <= data_d;
        end
    end

    // An ack in the final wait cycle still wins over the timeout.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        tmo_cnt_d = tmo_cnt_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_REQ;
                else state_d = ST_IDLE;
            end
            ST_REQ: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (sns_ack_i) begin
                    data_d  = sns_data_i;
                    state_d = ST_EVAL;
                end else if (tmo_cnt_q == LAST_TMO) begin
                    state_d = ST_NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_EVAL: state_d = ST_NEXT;
            ST_NEXT: begin
                if (ch_q == LAST_CH) ch_d = '0;
                else ch_d = ch_q + 1'b1;
                if (en_i) state_d = ST_REQ;
                else state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sns_req_o   = (state_q == ST_REQ) || (state_q == ST_WAIT);
        eval_s      = (state_q == ST_EVAL);
        tmo_s       = (state_q == ST_WAIT) && !sns_ack_i && (tmo_cnt_q == LAST_TMO);
        scan_done_o = (state_q == ST_NEXT) && (ch_q == LAST_CH);
    end

    assign sns_sel_o = ch_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        incubator_chan_mode #(
            .LO_TH    (LO_TH),
            .HI_TH    (HI_TH),
            .SETPT    (SETPT),
            .MIN_HOLD (MIN_HOLD)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .eval_i    (eval_s && (ch_q == CW'(i))),
            .tmo_i     (tmo_s && (ch_q == CW'(i))),
            .reading_i (data_q),
            .heater_o  (heater_o[i]),
            .cooler_o  (cooler_o[i]),
            .fault_o   (fault_o[i])
        );
    end

endmodule

// File: tb/tb_incubator_scan_ctrl.sv
// Randomized bench for incubator_scan_ctrl: a visit-timeline reference model predicts
// every output each cycle from the scan and hysteresis rules.
module tb_incubator_scan_ctrl;
    localparam int N    = 4;
    localparam int MINH = 8;
    localparam int TMO  = 16;
    localparam int LO   = 15;
    localparam int HI   = 35;
    localparam int SP   = 25;

    logic                   clk = 1'b0;
    logic                   rst, en, ack;
    logic signed [7:0]      data;
    logic [$clog2(N)-1:0]   sel;
    logic                   req, done;
    logic [N-1:0]           heat, cool, flt;

    int total = 0;
    int bad   = 0;

    // Reference model: visit timeline plus per-chamber mode/fault/last-zero-hold cycle.
    bit                busy;
    int                vs, vend, veval, vnext;
    bit                vtmo;
    int                ch;
    logic signed [7:0] rd;
    int                mode_m[N];
    bit                flt_m[N];
    int                lz[N];
    int                rd_tbl[16] = '{-128, -1, 0, 10, 14, 15, 16, 20, 24, 25, 26, 34, 35, 36, 40, 127};

    always #5 clk = ~clk;

    incubator_scan_ctrl #(.N_CH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .sns_sel_o   (sel),
        .sns_req_o   (req),
        .sns_ack_i   (ack),
        .sns_data_i  (data),
        .heater_o    (heat),
        .cooler_o    (cool),
        .fault_o     (flt),
        .scan_done_o (done)
    );

    task automatic check_eq(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int first);
        busy = 1'b0;
        ch   = 0;
        for (int i = 0; i < N; i++) begin
            mode_m[i] = 0;
            flt_m[i]  = 1'b0;
            lz[i]     = first;
        end
    endtask

    task automatic start_visit(input int s);
        int d;
        busy = 1'b1;
        vs   = s;
        if ($urandom_range(39) == 0) d = TMO;
        else if ($urandom_range(1) == 0) d = 0;
        else d = $urandom_range(TMO - 1);
        vtmo  = (d >= TMO);
        vend  = vtmo ? s + TMO : s + 1 + d;
        veval = vtmo ? -1 : vend + 1;
        vnext = vtmo ? vend + 1 : vend + 2;
        rd    = 8'(rd_tbl[$urandom_range(15)]);
        if ($urandom_range(4) == 0) rd = 8'($urandom);
    endtask

    // Mode 0=OFF 1=HEAT 2=COOL; hold is the number of cycles since the last mode change.
    task automatic model_eval(input int c);
        int r, m, w, h;
        r = int'(rd);
        m = mode_m[ch];
        w = m;
        if (m == 0 && r < LO) w = 1;
        else if (m == 0 && r > HI) w = 2;
        else if (m == 1 && r >= SP) w = 0;
        else if (m == 2 && r <= SP) w = 0;
        h = c - lz[ch];
        if (h > MINH) h = MINH;
        if (!flt_m[ch] && w != m && h >= MINH) begin
            mode_m[ch] = w;
            lz[ch]     = c + 1;
        end
    endtask

    initial begin
        bit rst_now, rst_pending;
        int late_ack_at, quiet_until;
        logic [N-1:0] eh, ec, ef;
        rst = 1'b1; en = 1'b0; ack = 1'b0; data = 8'sd0;
        rst_pending = 1'b0;
        late_ack_at = -1;
        quiet_until = 2;
        model_reset(0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                eh[i] = (mode_m[i] == 1);
                ec[i] = (mode_m[i] == 2);
                ef[i] = flt_m[i];
            end
            check_eq("sns_req",   cyc, 32'(req),  32'(busy && cyc >= vs && cyc <= vend));
            check_eq("sns_sel",   cyc, 32'(sel),  32'(ch));
            check_eq("scan_done", cyc, 32'(done), 32'(busy && cyc == vnext && ch == N - 1));
            check_eq("heater",    cyc, 32'(heat), 32'(eh));
            check_eq("cooler",    cyc, 32'(cool), 32'(ec));
            check_eq("fault",     cyc, 32'(flt),  32'(ef));

            if (cyc % 500 == 250) rst_pending = 1'b1;
            rst_now = (cyc < 3) || (rst_pending && busy && cyc > vs && cyc <= vend);
            if (rst_now && cyc >= 3) begin
                rst_pending = 1'b0;
                late_ack_at = cyc + 1;
                quiet_until = cyc + 3;
            end
            rst = rst_now;
            en  = (cyc <= quiet_until) ? 1'b0 : ($urandom_range(19) != 0);
            ack  = 1'b0;
            data = 8'($urandom);
            if (cyc == late_ack_at) begin
                ack  = 1'b1;
                data = 8'sd0;
            end else if (busy && !vtmo && cyc == vend) begin
                ack  = 1'b1;
                data = rd;
            end else if (!(busy && cyc > vs && cyc <= vend) && $urandom_range(7) == 0) begin
                ack = 1'b1;
            end

            if (rst_now) begin
                model_reset(cyc + 1);
            end else if (busy) begin
                if (cyc == veval) model_eval(cyc);
                if (vtmo && cyc == vend) begin
                    flt_m[ch] = 1'b1;
                    if (mode_m[ch] != 0) begin
                        mode_m[ch] = 0;
                        lz[ch]     = cyc + 1;
                    end
                end
                if (cyc == vnext) begin
                    ch   = (ch + 1) % N;
                    busy = 1'b0;
                    if (en) start_visit(cyc + 1);
                end
            end else if (en) begin
                start_visit(cyc + 1);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
